seg_scan_controller: RTL and testbench
======================================

# seg_scan_controller

Parametrised time-multiplexed scan controller for a common-anode seven-segment display bank. It replaces fixed two-digit anode selection with an internal refresh prescaler, N-digit round-robin scanning with per-digit enable masking, and a PWM brightness control. It also provides built-in hex-to-segment decoding and tear-free frame latching. It sits between the display-value logic and the board AN/SEG/DP pins.

## Interface
- `NUM_DIGITS`, default 8: number of anodes scanned (2..16).
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (≥16).
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `en`  in  1: scan enable. When 0, all anodes are off and the prescaler is held at 0.
- `digit_mask`  in  NUM_DIGITS: 1 means the digit takes part in the scan.
- `digits`  in  4*NUM_DIGITS: hex nibble per digit; digit i is `[4i+3:4i]`.
- `dp_in`  in  NUM_DIGITS: decimal point request per digit, active-high.
- `brightness`  in  4: 0 is dimmest and 15 is full on.
- `AN`  out  NUM_DIGITS: anodes, active-low, registered.
- `SEG`  out  7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `DP`  out  1: decimal point, active-low, registered.
- `frame_tick`  out  1: one-cycle pulse each time the scan wraps.

## Operation
- **Prescaler `pcnt`**
  - Counts 0..REFRESH_DIV-1 while `en`=1.
  - The slot ends when `pcnt`=REFRESH_DIV-1. Next cycle `pcnt`=0.
- **Digit index `idx`**
  - At slot end, `idx` advances to the first set `digit_mask` bit, searching idx+1 upward and wrapping at NUM_DIGITS-1 to 0.
  - If no other bit is set, `idx` stays where it is.
  - If `digit_mask`=0, `idx` holds and all anodes stay off.
- **Frame tick**
  - `frame_tick`=1 for one cycle when the new `idx` ≤ old `idx` at slot end.
  - With a single enabled digit, every slot is therefore a frame.
- **Shadow registers**
  - `digits` and `dp_in` are copied into shadow registers on the cycle `frame_tick` is asserted.
  - SEG and DP are driven only from the shadow copy, so inputs changing mid-frame cause no tearing.
- **Brightness gating**
  - `on_limit` = ((brightness+1) × REFRESH_DIV) >> 4, integer arithmetic, evaluated with at least 32 bits.
  - The anode for the current `idx` is driven low only while `pcnt` < `on_limit` AND `digit_mask[idx]`=1 AND `en`=1.
  - brightness=15 gives 100% on-time.
- **Decoding**
  - SEG is the standard hex pattern for shadow nibble `idx`, covering 0-9 and A, b, C, d, E, F.
  - DP = ~shadow_dp[`idx`].
- **Masking mid-slot**
  - Clearing `digit_mask[idx]` turns that anode off on the next edge.
  - The index does not move until slot end.
- **Enable**
  - Dropping `en` gives AN all-ones next edge, `pcnt`=0, and `idx` held.
  - Re-enable resumes at the held `idx`.

## Timing
- **Reset values:** AN all ones, SEG=7'h7F, DP=1, `frame_tick`=0, `idx`=0, `pcnt`=0, shadows=0.
- **Output latency:** AN, SEG and DP reflect `idx`/`pcnt` state with one register stage of latency.
- **Slot-boundary switching:** the new anode and its segments change on the same edge, with no cycle where the old segments show on the new anode.
- **Frame-boundary data:** a new `digits` value first appears on the slot that begins with the `frame_tick` pulse.
- **Reset mid-operation:** asynchronous. Outputs go to reset values immediately, and operation resumes from `idx`=0 after release.
- **Full scan period:** popcount(`digit_mask`) × REFRESH_DIV cycles.

## Structure
- **Shared package `seg_scan_pkg`** holds:
  - the 16-entry segment pattern constants;
  - SEG_BLANK=7'h7F;
  - the brightness width constant, 4.
- **Sub-module `hex_to_seg7`:** a combinational 4-bit to 7-bit active-low decoder, instantiated once and fed by the shadow nibble mux.
- **Top-level contents:** prescaler, next-enabled-digit search, shadow registers, PWM compare, output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=16, mask=4'hF, brightness=15.
- **Reset and full scan:**
  - Stimulus: release `rst_n`, then digits=16'h3210.
  - Response: after the first frame, AN cycles 1110→1101→1011→0111, with each digit low for 16 cycles. SEG shows 0,1,2,3 (7'h40, 7'h79, 7'h24, 7'h30). `frame_tick` pulses every 64 cycles.
- **Masking:**
  - Stimulus: mask=4'b0101.
  - Response: only AN=1110 and 1011 alternate. `frame_tick` pulses every 32 cycles. mask=0 gives AN=1111 constantly.
- **Brightness:**
  - Stimulus: brightness=3.
  - Response: `on_limit`=4, so each anode is low for 4 of 16 cycles. brightness=0 gives `on_limit`=1, one cycle low.
- **Tear-free update:**
  - Stimulus: change `digits` from 16'h3210 to 16'hABCD mid-frame.
  - Response: the remaining slots still show the old values. The new values appear starting with the slot that begins at the next `frame_tick`.
- **Enable and async reset:**
  - Stimulus: `en`=0 during digit 2.
  - Response: AN=1111 next edge. After `en`=1, digit 2 resumes from `pcnt`=0.
  - Stimulus: `rst_n` low mid-slot.
  - Response: AN=1111, SEG=7'h7F and DP=1 without waiting for a clock edge.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan controller: segment patterns,
// blank pattern and brightness width.
package seg_scan_pkg;

    localparam int BRIGHT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_controller_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Zero latency; no flow control.
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg_scan_controller.sv
// Round-robin seven-segment scanner with prescaler, digit masking, PWM dimming
// and frame-latched digit data. Outputs are registered (one cycle after state).
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              SEG,
    output logic                    DP,
    output logic                    frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sdig_q, sdig_d;
    logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    ft_q, ft_d;

    logic                    slot_end;
    logic                    wrap;
    logic                    found;
    logic [IW-1:0]           cand;
    logic [IW-1:0]           nxt_idx;
    logic [31:0]             on_limit;
    logic [6:0]              cur_seg;

    assign slot_end = en && (pcnt_q == PW'(REFRESH_DIV - 1));
    assign on_limit = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> 4;

    // Next enabled digit after idx, wrapping; idx itself is the last candidate.
    always_comb begin
        nxt_idx = idx_q;
        found   = 1'b0;
        cand    = idx_q;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            cand = IW'((int'(idx_q) + k) % NUM_DIGITS);
            if (!found && digit_mask[cand]) begin
                nxt_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign wrap = slot_end && (nxt_idx <= idx_q);

    hex_to_seg7 u_dec (
        .nib_i (sdig_q[{idx_q, 2'b00} +: 4]),
        .seg_o (cur_seg)
    );

    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        idx_d  = idx_q;
        sdig_d = sdig_q;
        sdp_d  = sdp_q;
        ft_d   = wrap;
        if (!en || slot_end) begin
            pcnt_d = '0;
        end
        if (slot_end) begin
            idx_d = nxt_idx;
        end
        // Latch on the wrap edge so the first slot of the new frame already sees it.
        if (wrap) begin
            sdig_d = digits;
            sdp_d  = dp_in;
        end

        an_d = '1;
        if (en && digit_mask[idx_q] && (32'(pcnt_q) < on_limit)) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d = cur_seg;
        dp_d  = ~sdp_q[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            idx_q  <= '0;
            sdig_q <= '0;
            sdp_q  <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            ft_q   <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            sdig_q <= sdig_d;
            sdp_q  <= sdp_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            ft_q   <= ft_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: slot-level reference model plus directed checks.
module tb_seg_scan_controller;

    localparam int ND = 4;
    localparam int RD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [ND-1:0] digit_mask = 4'hF;
    logic [4*ND-1:0] digits = '0;
    logic [ND-1:0] dp_in = '0;
    logic [3:0]    brightness = 4'd15;
    logic [ND-1:0] an_w;
    logic [6:0]    seg_w;
    logic          dp_w;
    logic          ft_w;

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;

    // Reference model state
    int            m_pcnt;
    logic [1:0]    m_idx;
    logic [15:0]   m_sdig;
    logic [3:0]    m_sdp;
    logic [3:0]    e_an;
    logic [6:0]    e_seg;
    logic          e_dp;
    logic          e_ft;

    seg_scan_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_mask (digit_mask),
        .digits     (digits),
        .dp_in      (dp_in),
        .brightness (brightness),
        .AN         (an_w),
        .SEG        (seg_w),
        .DP         (dp_w),
        .frame_tick (ft_w)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic model_reset();
        m_pcnt = 0; m_idx = 2'd0; m_sdig = '0; m_sdp = '0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    endtask

    // Outputs follow from the state at the edge; then the slot rules advance the state.
    task automatic model_step();
        int on_limit;
        int j;
        logic [1:0] n;
        bit hit;
        on_limit = ((int'(brightness) + 1) * RD) / 16;
        e_an = 4'hF;
        if (en && digit_mask[m_idx] && m_pcnt < on_limit) e_an[m_idx] = 1'b0;
        e_seg = ref_seg(m_sdig[{m_idx, 2'b00} +: 4]);
        e_dp  = ~m_sdp[m_idx];
        e_ft  = 1'b0;
        if (!en) begin
            m_pcnt = 0;
        end else if (m_pcnt == RD - 1) begin
            m_pcnt = 0;
            n = m_idx;
            hit = 1'b0;
            for (int k = 1; k <= ND; k++) begin
                j = (int'(m_idx) + k) % ND;
                if (!hit && digit_mask[j]) begin
                    n = 2'(j);
                    hit = 1'b1;
                end
            end
            if (n <= m_idx) begin
                e_ft = 1'b1;
                m_sdig = digits;
                m_sdp = dp_in;
            end
            m_idx = n;
        end else begin
            m_pcnt = m_pcnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        ncmp++;
        if ({an_w, seg_w, dp_w, ft_w} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL reset: got an=%b seg=%h dp=%b ft=%b want an=1111 seg=7f dp=1 ft=0",
                     an_w, seg_w, dp_w, ft_w);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_scan();
        int last_ft;
        last_ft = -1;
        en = 1'b1; digit_mask = 4'hF; brightness = 4'd15; digits = 16'h3210; dp_in = 4'b0100;
        repeat (260) begin
            tick();
            ncmp++;
            if ({an_w, seg_w, dp_w, ft_w} !== {e_an, e_seg, e_dp, e_ft}) begin
                nerr++;
                $display("FAIL full_scan @%0d: got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                         cyc, an_w, seg_w, dp_w, ft_w, e_an, e_seg, e_dp, e_ft);
            end
            if (ft_w) begin
                if (last_ft >= 0) begin
                    ncmp++;
                    if (cyc - last_ft != 64) begin
                        nerr++;
                        $display("FAIL full_scan_period: got %0d want 64", cyc - last_ft);
                    end
                end
                last_ft = cyc;
            end
        end
    endtask

    task automatic test_masking();
        int last_ft;
        last_ft = -1;
        digit_mask = 4'b0101;
        repeat (150) begin
            tick();
            ncmp++;
            if ({an_w, seg_w, dp_w, ft_w} !== {e_an, e_seg, e_dp, e_ft}) begin
                nerr++;
                $display("FAIL masking @%0d: got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b",
                         cyc, an_w, seg_w, ft_w, e_an, e_seg, e_ft);
            end
            if (an_w != 4'b1110 && an_w != 4'b1011 && cyc > 0) begin
                if (an_w != 4'hF) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL masking_anode: got %b want 1110 or 1011", an_w);
                end
            end
            if (ft_w) begin
                if (last_ft >= 0) begin
                    ncmp++;
                    if (cyc - last_ft != 32) begin
                        nerr++;
                        $display("FAIL masking_period: got %0d want 32", cyc - last_ft);
                    end
                end
                last_ft = cyc;
            end
        end
        digit_mask = 4'h0;
        tick();
        repeat (40) begin
            tick();
            ncmp++;
            if (an_w !== 4'hF) begin
                nerr++;
                $display("FAIL mask_zero: got an=%b want 1111", an_w);
            end
        end
        digit_mask = 4'hF;
        repeat (20) tick();
    endtask

    task automatic test_brightness();
        int low;
        logic [3:0] lvl [2] = '{4'd3, 4'd0};
        int want [2] = '{16, 4};
        for (int t = 0; t < 2; t++) begin
            brightness = lvl[t];
            repeat (2) tick();
            low = 0;
            repeat (64) begin
                tick();
                ncmp++;
                if ({an_w, seg_w, dp_w, ft_w} !== {e_an, e_seg, e_dp, e_ft}) begin
                    nerr++;
                    $display("FAIL brightness @%0d: got an=%b want an=%b", cyc, an_w, e_an);
                end
                if (an_w != 4'hF) low++;
            end
            ncmp++;
            if (low != want[t]) begin
                nerr++;
                $display("FAIL brightness_on_time b=%0d: got %0d want %0d", lvl[t], low, want[t]);
            end
        end
        brightness = 4'd15;
    endtask

    task automatic test_tear_free();
        int n;
        digits = 16'h3210;
        n = 0;
        for (int c = 0; c < 400 && n < 2; c++) begin
            tick();
            if (ft_w) n++;
        end
        for (int c = 0; c < 100 && !(m_idx == 2'd1 && m_pcnt == 6); c++) tick();
        digits = 16'hABCD;
        for (int c = 0; c < 100 && an_w != 4'b1011; c++) tick();
        ncmp++;
        if (an_w !== 4'b1011 || seg_w !== 7'h24) begin
            nerr++;
            $display("FAIL tear_old: got an=%b seg=%h want an=1011 seg=24", an_w, seg_w);
        end
        for (int c = 0; c < 100 && !ft_w; c++) tick();
        tick();
        ncmp++;
        if (an_w !== 4'b1110 || seg_w !== 7'h21) begin
            nerr++;
            $display("FAIL tear_new: got an=%b seg=%h want an=1110 seg=21", an_w, seg_w);
        end
        repeat (80) begin
            tick();
            ncmp++;
            if ({an_w, seg_w, dp_w, ft_w} !== {e_an, e_seg, e_dp, e_ft}) begin
                nerr++;
                $display("FAIL tear_model @%0d: got an=%b seg=%h want an=%b seg=%h",
                         cyc, an_w, seg_w, e_an, e_seg);
            end
        end
    endtask

    task automatic test_enable();
        int low;
        for (int c = 0; c < 100 && !(m_idx == 2'd2 && m_pcnt == 5); c++) tick();
        en = 1'b0;
        tick();
        ncmp++;
        if (an_w !== 4'hF) begin
            nerr++;
            $display("FAIL enable_off: got an=%b want 1111", an_w);
        end
        repeat (7) tick();
        en = 1'b1;
        tick();
        ncmp++;
        if (an_w !== 4'b1011) begin
            nerr++;
            $display("FAIL enable_resume: got an=%b want 1011", an_w);
        end
        low = 1;
        repeat (16) begin
            tick();
            if (an_w == 4'b1011) low++;
            ncmp++;
            if ({an_w, seg_w, dp_w, ft_w} !== {e_an, e_seg, e_dp, e_ft}) begin
                nerr++;
                $display("FAIL enable_model @%0d: got an=%b want an=%b", cyc, an_w, e_an);
            end
        end
        ncmp++;
        if (low != 16) begin
            nerr++;
            $display("FAIL enable_slot_len: got %0d want 16", low);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 100 && !(m_idx == 2'd1 && m_pcnt == 7); c++) tick();
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if ({an_w, seg_w, dp_w, ft_w} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL async_reset: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
                     an_w, seg_w, dp_w);
        end
        @(negedge clk);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) begin
            tick();
            ncmp++;
            if ({an_w, seg_w, dp_w, ft_w} !== {e_an, e_seg, e_dp, e_ft}) begin
                nerr++;
                $display("FAIL after_reset @%0d: got an=%b seg=%h want an=%b seg=%h",
                         cyc, an_w, seg_w, e_an, e_seg);
            end
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) digit_mask = 4'($urandom);
            if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 63) == 0) en = ~en;
            tick();
            ncmp++;
            if ({an_w, seg_w, dp_w, ft_w} !== {e_an, e_seg, e_dp, e_ft}) begin
                nerr++;
                $display("FAIL random @%0d: got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                         cyc, an_w, seg_w, dp_w, ft_w, e_an, e_seg, e_dp, e_ft);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_masking();
        test_brightness();
        test_tear_free();
        test_enable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
